proc_mem_arb: RTL and testbench

Two-to-one memory port arbiter for the processor. It merges the datapath's instruction-memory port and data-memory port onto a single shared memory port. Arbitration between the two is round-robin. A tag FIFO records which port each accepted request came from, and in-order responses are routed back to the originating port. The block sits between `proc_dpath`'s imem/dmem ports and a single-ported cache or test memory, and adds zero cycles of latency on both paths.

---
 rtl/proc_mem_arb.sv | 134 +++++++++++++
 tb/tb_proc_mem_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mem_arb.sv
// rtl/proc_mem_arb.sv - round-robin 2:1 imem/dmem arbiter with in-order response routing
module proc_mem_arb #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int REQ_W  = 77,
  parameter int RESP_W = 47,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = $clog2(MAX_OUTSTANDING)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [REQ_W-1:0]  imemreq_msg,
  input  logic              imemreq_val,
  output logic              imemreq_rdy,
  output logic [RESP_W-1:0] imemresp_msg,
  output logic              imemresp_val,
  input  logic              imemresp_rdy,

  input  logic [REQ_W-1:0]  dmemreq_msg,
  input  logic              dmemreq_val,
  output logic              dmemreq_rdy,
  output logic [RESP_W-1:0] dmemresp_msg,
  output logic              dmemresp_val,
  input  logic              dmemresp_rdy,

  output logic [REQ_W-1:0]  memreq_msg,
  output logic              memreq_val,
  input  logic              memreq_rdy,
  input  logic [RESP_W-1:0] memresp_msg,
  input  logic              memresp_val,
  output logic              memresp_rdy,

  output logic [CW-1:0]     outstanding,
  output logic              err_orphan_resp
);

  // Tag encoding: 1 = imem, 0 = dmem. r_prio holds the preferred tag.
  logic [MAX_OUTSTANDING-1:0] r_tags;
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_prio;
  logic                       r_err;

  logic w_full;
  logic w_empty;
  logic w_grant_val;
  logic w_grant_id;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_orphan;

  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_head  = r_tags[r_rd_ptr];

  // Grant selection; a pop this cycle never frees a slot until the next edge.
  always_comb begin
    w_grant_val = 1'b0;
    w_grant_id  = 1'b0;
    if (!reset && !w_full) begin
      if (imemreq_val && dmemreq_val) begin
        w_grant_val = 1'b1;
        w_grant_id  = r_prio;
      end else if (imemreq_val) begin
        w_grant_val = 1'b1;
        w_grant_id  = 1'b1;
      end else if (dmemreq_val) begin
        w_grant_val = 1'b1;
        w_grant_id  = 1'b0;
      end
    end
  end

  // Request mux and ready steering toward the granted port only.
  always_comb begin
    memreq_val  = w_grant_val;
    memreq_msg  = w_grant_id ? imemreq_msg : dmemreq_msg;
    imemreq_rdy = w_grant_val &&  w_grant_id && memreq_rdy;
    dmemreq_rdy = w_grant_val && !w_grant_id && memreq_rdy;
    w_push      = w_grant_val && memreq_rdy;
  end

  // Response steering by head tag; with nothing outstanding, drain and flag orphans.
  always_comb begin
    imemresp_msg = memresp_msg;
    dmemresp_msg = memresp_msg;
    imemresp_val = 1'b0;
    dmemresp_val = 1'b0;
    memresp_rdy  = 1'b1;
    if (!w_empty) begin
      imemresp_val = memresp_val &&  w_head;
      dmemresp_val = memresp_val && !w_head;
      memresp_rdy  = w_head ? imemresp_rdy : dmemresp_rdy;
    end
    w_pop    = memresp_val && memresp_rdy && !w_empty;
    w_orphan = memresp_val && w_empty && !reset;
  end

  // Pointers, occupancy, round-robin priority and sticky orphan flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_prio   <= ~w_grant_id;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

  // Tag storage; entries are only meaningful between their push and pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= w_grant_id;
    end
  end

  assign outstanding     = r_count;
  assign err_orphan_resp = r_err;

endmodule

// File: tb/tb_proc_mem_arb.sv
// tb/tb_proc_mem_arb.sv - scoreboard bench for proc_mem_arb
module tb_proc_mem_arb;
  localparam int REQ_W  = 77;
  localparam int RESP_W = 47;

  logic              clk = 1'b0;
  logic              reset;
  logic [REQ_W-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
  logic              imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic [RESP_W-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic              imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;
  logic              memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [2:0]        outstanding;
  logic              err_orphan_resp;

  int total = 0;
  int bad   = 0;

  logic [REQ_W-1:0] q_req[$];
  logic [32:0]      q_resp[$];
  bit               m_tags[$];

  proc_mem_arb #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .outstanding(outstanding), .err_orphan_resp(err_orphan_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk_req(input logic [7:0] op, input logic [31:0] addr);
    return {3'd0, op, addr, 2'd0, 32'd0};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [7:0] op, input logic [31:0] data);
    return {3'd0, op, 2'd0, 2'd0, data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic resp_chk(input bit port, input logic [31:0] data);
    logic [32:0] e;
    total++;
    if (q_resp.size() == 0) begin
      bad++;
      $display("FAIL resp_unexpected: got port %0d data %0h want none", port, data);
    end else begin
      e = q_resp.pop_front();
      if (e !== {port, data}) begin
        bad++;
        $display("FAIL resp_route: got port %0d data %0h want port %0d data %0h",
                 port, data, e[32], e[31:0]);
      end
    end
  endtask

  // Monitor: every fire on the shared request or either response port is scored.
  always @(negedge clk) begin
    logic [REQ_W-1:0] e;
    if (!reset) begin
      if (memreq_val && memreq_rdy) begin
        total++;
        if (q_req.size() == 0) begin
          bad++;
          $display("FAIL req_unexpected: got %0h want none", memreq_msg);
        end else begin
          e = q_req.pop_front();
          if (memreq_msg !== e) begin
            bad++;
            $display("FAIL req_msg: got %0h want %0h", memreq_msg, e);
          end
        end
      end
      if (imemresp_val && imemresp_rdy) resp_chk(1'b1, imemresp_msg[31:0]);
      if (dmemresp_val && dmemresp_rdy) resp_chk(1'b0, dmemresp_msg[31:0]);
      if (imemresp_val && dmemresp_val) begin
        total++;
        bad++;
        $display("FAIL resp_both_val: got 1,1 want at most one");
      end
    end
  end

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit port, input logic [REQ_W-1:0] m);
    if (port) begin imemreq_val = 1'b1; imemreq_msg = m; end
    else      begin dmemreq_val = 1'b1; dmemreq_msg = m; end
    q_req.push_back(m);
    settle();
    adv();
    imemreq_val = 1'b0;
    dmemreq_val = 1'b0;
  endtask

  task automatic respond(input bit port, input logic [31:0] data);
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'hE0, data);
    q_resp.push_back({port, data});
    settle();
    adv();
    memresp_val = 1'b0;
  endtask

  logic [REQ_W-1:0] m_i, m_d;

  initial begin
    reset = 1'b1;
    imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b0;
    imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1; memreq_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset defaults and alternating grants from dmem
    settle();
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_orphan_resp, 0);
    check("rst_memreq_val", memreq_val, 0);
    adv();
    m_i = mk_req(8'h01, 32'h200);
    m_d = mk_req(8'h02, 32'h1000);
    imemreq_msg = m_i; dmemreq_msg = m_d;
    imemreq_val = 1'b1; dmemreq_val = 1'b1;
    q_req.push_back(m_d); q_req.push_back(m_i);
    q_req.push_back(m_d); q_req.push_back(m_i);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("rr_dmem_rdy", dmemreq_rdy, (i % 2 == 0) ? 1 : 0);
      check("rr_outstanding", outstanding, i);
      adv();
    end
    settle();
    check("full_no_grant", memreq_val, 0);
    check("full_outstanding", outstanding, 4);
    adv();
    imemreq_val = 1'b0; dmemreq_val = 1'b0;
    respond(1'b0, 32'h10); respond(1'b1, 32'h11);
    respond(1'b0, 32'h12); respond(1'b1, 32'h13);
    settle();
    check("drain1_outstanding", outstanding, 0);
    adv();

    // 2: routing of an imem then a dmem response
    issue(1'b1, mk_req(8'h21, 32'h200));
    issue(1'b0, mk_req(8'h22, 32'h1000));
    settle(); check("route_out2", outstanding, 2); adv();
    respond(1'b1, 32'hAAAA);
    settle(); check("route_out1", outstanding, 1); adv();
    respond(1'b0, 32'hBBBB);
    settle(); check("route_out0", outstanding, 0); adv();

    // 3: response backpressure on imem
    issue(1'b1, mk_req(8'h31, 32'h300));
    imemresp_rdy = 1'b0;
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'h31, 32'hC0C0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_memresp_rdy", memresp_rdy, 0);
      check("bp_imemresp_val", imemresp_val, 1);
      check("bp_outstanding", outstanding, 1);
      adv();
    end
    imemresp_rdy = 1'b1;
    q_resp.push_back({1'b1, 32'hC0C0});
    settle(); check("bp_release_rdy", memresp_rdy, 1); adv();
    memresp_val = 1'b0;
    settle(); check("bp_popped", outstanding, 0); adv();

    // 4: pop while full does not grant in the same cycle
    m_d = mk_req(8'h41, 32'h4000);
    dmemreq_msg = m_d; dmemreq_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_req.push_back(m_d);
      settle();
      adv();
    end
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'h41, 32'h4444);
    q_resp.push_back({1'b0, 32'h4444});
    settle();
    check("fb_pop_no_grant", memreq_val, 0);
    check("fb_out4", outstanding, 4);
    adv();
    memresp_val = 1'b0;
    q_req.push_back(m_d);
    settle();
    check("fb_next_grant", memreq_val, 1);
    check("fb_out3", outstanding, 3);
    adv();
    dmemreq_val = 1'b0;
    settle(); check("fb_out4_again", outstanding, 4); adv();
    for (int i = 0; i < 4; i++) respond(1'b0, 32'h4400 + i);

    // 5: simultaneous push and pop at two outstanding, across pointer wrap
    issue(1'b1, mk_req(8'h50, 32'h5000)); m_tags.push_back(1'b1);
    issue(1'b0, mk_req(8'h51, 32'h5004)); m_tags.push_back(1'b0);
    for (int k = 0; k < 10; k++) begin
      bit p;
      logic [REQ_W-1:0] m;
      p = (k % 3 == 0);
      m = mk_req(8'h60 + 8'(k), 32'h6000 + 32'(k * 4));
      imemreq_val = p; dmemreq_val = !p;
      if (p) imemreq_msg = m; else dmemreq_msg = m;
      q_req.push_back(m);
      memresp_val = 1'b1;
      memresp_msg = mk_resp(8'h70, 32'h7000 + 32'(k));
      q_resp.push_back({m_tags[0], 32'h7000 + 32'(k)});
      settle();
      check("pp_outstanding", outstanding, 2);
      adv();
      void'(m_tags.pop_front());
      m_tags.push_back(p);
    end
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b0;
    while (m_tags.size() > 0) respond(m_tags.pop_front(), 32'h7F00 + 32'(m_tags.size()));
    settle(); check("pp_drained", outstanding, 0); adv();

    // 6: asynchronous mid-operation reset, then an orphan response
    m_d = mk_req(8'h81, 32'h8000);
    dmemreq_msg = m_d; dmemreq_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_req.push_back(m_d);
      settle();
      adv();
    end
    #1 reset = 1'b1;
    #1;
    check("ar_outstanding", outstanding, 0);
    check("ar_memreq_val", memreq_val, 0);
    dmemreq_val = 1'b0;
    #1 reset = 1'b0;
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'h82, 32'hDEAD);
    settle();
    check("orph_memresp_rdy", memresp_rdy, 1);
    check("orph_imem_val", imemresp_val, 0);
    check("orph_dmem_val", dmemresp_val, 0);
    check("orph_err_before", err_orphan_resp, 0);
    adv();
    memresp_val = 1'b0;
    settle();
    check("orph_err", err_orphan_resp, 1);
    check("orph_outstanding", outstanding, 0);
    adv();
    settle();
    check("orph_err_sticky", err_orphan_resp, 1);

    check("req_queue_left", q_req.size(), 0);
    check("resp_queue_left", q_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
